// File: rtl/y86_pkg.sv
// Shared status codes and arbiter state encoding for the unified-memory port arbiter.
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_D_BEAT = 2'd1,
        ARB_I_LO   = 2'd2,
        ARB_I_HI   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Beat watchdog: counts cycles a memory beat has waited for its acknowledge.
module arb_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    // Flags the wait cycle whose increment brings the count up to LIMIT.
    assign expired = en & (count == 4'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (two beats) and the data stage (one beat).
module mem_port_arbiter
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic              f_cancel,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              f_done,
    output logic [79:0]       f_instr,
    output logic [1:0]        f_stat,
    output logic              m_done,
    output logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        m_stat,
    output logic              f_stall_req,
    output logic              m_stall_req
);

    // Highest legal start address for an 8-byte data access and a 10-byte fetch;
    // comparing the start address avoids wrap-around of addr+offset.
    localparam logic [ADDR_W-1:0] M_LAST_START = ADDR_W'(MEM_BYTES - 8);
    localparam logic [ADDR_W-1:0] F_LAST_START = ADDR_W'(MEM_BYTES - 10);

    arb_state_t state, next_state;

    logic m_bad, f_bad, beat_ack, expired, squash, cancel_pend;
    logic start_d, start_lo, start_hi, err_d, err_f, beat_end, abort;

    assign m_bad    = m_addr > M_LAST_START;
    assign f_bad    = f_pc > F_LAST_START;
    assign beat_ack = mem_req & mem_ack;
    assign squash   = f_cancel | cancel_pend;

    assign f_stall_req = f_req & ~f_done;
    assign m_stall_req = m_req & ~m_done;

    arb_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_d | start_lo | start_hi),
        .en      (mem_req & ~mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // No new request is taken while a done pulse is out: the requester's level is still the old one.
    always_comb begin
        next_state = state;
        start_d    = 1'b0;
        start_lo   = 1'b0;
        start_hi   = 1'b0;
        err_d      = 1'b0;
        err_f      = 1'b0;
        beat_end   = 1'b0;
        abort      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!(f_done | m_done)) begin
                    if (m_req) begin
                        if (m_bad) begin
                            err_d = 1'b1;
                        end else begin
                            start_d    = 1'b1;
                            next_state = ARB_D_BEAT;
                        end
                    end else if (f_req && !f_cancel) begin
                        if (f_bad) begin
                            err_f = 1'b1;
                        end else begin
                            start_lo   = 1'b1;
                            next_state = ARB_I_LO;
                        end
                    end
                end
            end
            ARB_D_BEAT: begin
                if (beat_ack) begin
                    beat_end   = 1'b1;
                    next_state = ARB_IDLE;
                end else if (expired) begin
                    abort      = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            ARB_I_LO: begin
                if (beat_ack) begin
                    beat_end   = 1'b1;
                    next_state = squash ? ARB_IDLE : ARB_I_HI;
                end else if (expired) begin
                    abort      = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            ARB_I_HI: begin
                if (!mem_req) begin
                    if (squash) begin
                        next_state = ARB_IDLE;
                    end else begin
                        start_hi = 1'b1;
                    end
                end else if (beat_ack) begin
                    beat_end   = 1'b1;
                    next_state = ARB_IDLE;
                end else if (expired) begin
                    abort      = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cancel_pend <= 1'b0;
        end else if (next_state == ARB_IDLE) begin
            cancel_pend <= 1'b0;
        end else if (f_cancel && (state == ARB_I_LO || state == ARB_I_HI)) begin
            cancel_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_done    <= 1'b0;
            f_instr   <= '0;
            f_stat    <= STAT_AOK;
            m_done    <= 1'b0;
            m_rdata   <= '0;
            m_stat    <= STAT_AOK;
        end else begin
            f_done <= 1'b0;
            m_done <= 1'b0;
            if (start_d) begin
                mem_req   <= 1'b1;
                mem_we    <= m_we;
                mem_addr  <= m_addr;
                mem_wdata <= m_wdata;
            end
            if (start_lo) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= f_pc;
            end
            if (start_hi) begin
                mem_req  <= 1'b1;
                mem_addr <= mem_addr + ADDR_W'(8);
            end
            if (beat_end || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (err_d) begin
                m_done  <= 1'b1;
                m_stat  <= STAT_ADR;
                m_rdata <= '0;
            end
            if (err_f) begin
                f_done  <= 1'b1;
                f_stat  <= STAT_ADR;
                f_instr <= '0;
            end
            if (beat_end) begin
                case (state)
                    ARB_D_BEAT: begin
                        m_done  <= 1'b1;
                        m_stat  <= STAT_AOK;
                        m_rdata <= mem_we ? '0 : mem_rdata;
                    end
                    ARB_I_LO: f_instr[63:0] <= mem_rdata;
                    ARB_I_HI: begin
                        f_instr[79:64] <= mem_rdata[15:0];
                        if (!squash) begin
                            f_done <= 1'b1;
                            f_stat <= STAT_AOK;
                        end
                    end
                    default: ;
                endcase
            end
            // A watchdog abort is reported to whichever stage owned the beat, unless the fetch was squashed.
            if (abort) begin
                if (state == ARB_D_BEAT) begin
                    m_done  <= 1'b1;
                    m_stat  <= STAT_ADR;
                    m_rdata <= '0;
                end else if (!squash) begin
                    f_done  <= 1'b1;
                    f_stat  <= STAT_ADR;
                    f_instr <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner-case sequences and randomized ops vs. a word-level model.
module tb_mem_port_arbiter;
    import y86_pkg::*;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_cancel, m_req, m_we;
    logic [63:0] f_pc, m_addr, m_wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        f_done, m_done, f_stall_req, m_stall_req;
    logic [79:0] f_instr;
    logic [1:0]  f_stat, m_stat;
    logic [63:0] m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(MEM_BYTES), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_pc(f_pc), .f_cancel(f_cancel),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .f_done(f_done), .f_instr(f_instr), .f_stat(f_stat),
        .m_done(m_done), .m_rdata(m_rdata), .m_stat(m_stat),
        .f_stall_req(f_stall_req), .m_stall_req(m_stall_req)
    );

    int checks = 0;
    int failures = 0;
    int mem_lat = 1;
    bit hold_ack = 1'b0;
    int ack_count = 0;
    int wait_cnt = 0;

    logic [63:0] phys_mem [logic [63:0]];
    logic [63:0] ref_mem  [logic [63:0]];

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0] + 32'h0000_0777};
    endfunction

    function automatic logic [63:0] phys_rd(input logic [63:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        phys_mem[a] = d;
        ref_mem[a]  = d;
    endtask

    task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after mem_lat cycles of mem_req, word-addressed store.
    always @(negedge clk) begin
        if (!mem_req || mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            wait_cnt++;
            if (!hold_ack && wait_cnt >= mem_lat) begin
                mem_ack   = 1'b1;
                ack_count++;
                mem_rdata = phys_rd(mem_addr);
                if (mem_we) phys_mem[mem_addr] = mem_wdata;
            end
        end
    end

    // Reference: a request either lies wholly inside memory or reports STAT_ADR with zero data.
    task automatic ref_op(input bit is_fetch, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [1:0] stat, output logic [79:0] data);
        logic [64:0] last_byte;
        logic [63:0] lo, hi;
        last_byte = {1'b0, addr} + (is_fetch ? 65'd9 : 65'd7);
        stat = STAT_AOK;
        data = '0;
        if (last_byte >= 65'(MEM_BYTES)) begin
            stat = STAT_ADR;
        end else if (is_fetch) begin
            lo   = ref_rd(addr);
            hi   = ref_rd(addr + 64'd8);
            data = {hi[15:0], lo};
        end else if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            data = {16'h0, ref_rd(addr)};
        end
    endtask

    task automatic apply_stimulus(input bit is_fetch, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                                  input int lat, output logic [1:0] got_stat, output logic [79:0] got_data,
                                  output bit proto_bad);
        bit seen;
        seen = 1'b0;
        proto_bad = 1'b0;
        got_stat = 2'b11;
        got_data = '1;
        mem_lat = lat;
        if (is_fetch) begin
            f_pc = addr; f_req = 1'b1;
        end else begin
            m_addr = addr; m_we = we; m_wdata = wdata; m_req = 1'b1;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (f_done && m_done) proto_bad = 1'b1;
            if (is_fetch ? f_done : m_done) begin
                seen = 1'b1;
                break;
            end
            if ((is_fetch ? f_stall_req : m_stall_req) !== 1'b1) proto_bad = 1'b1;
        end
        if (seen) begin
            if ((is_fetch ? f_stall_req : m_stall_req) !== 1'b0) proto_bad = 1'b1;
            got_stat = is_fetch ? f_stat : m_stat;
            got_data = is_fetch ? f_instr : {16'h0, m_rdata};
        end else begin
            check_output("done_timeout", 80'd0, 80'd1);
        end
        f_req = 1'b0;
        m_req = 1'b0;
        @(negedge clk);
        if ((is_fetch ? f_done : m_done) !== 1'b0) proto_bad = 1'b1;
    endtask

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic [1:0]  exp_stat;
        logic [79:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    logic [1:0]  got_stat, exp_stat;
    logic [79:0] got_data, exp_data;
    bit          proto_bad, got, unstable, stall_bad, found, f_seen;
    int          edges, high, m_at, f_at, acks0, kind;
    logic [63:0] log_q[$];
    logic [63:0] first_addr, a0, a1, raddr;
    logic        first_we;

    initial begin
        rst_n = 1'b0; f_req = 1'b0; f_cancel = 1'b0; m_req = 1'b0; m_we = 1'b0;
        f_pc = '0; m_addr = '0; m_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        preload(64'h10,  64'h1122_3344_5566_7788);
        preload(64'h18,  64'hFFEE_DDCC_BBAA_AABB);
        preload(64'h100, 64'hCAFE_F00D_1234_5678);
        preload(64'hFF6, 64'h0102_0304_0506_0708);
        preload(64'hFFE, 64'h1111_2222_3333_C0DE);
        preload(64'hFF8, 64'h8877_6655_4433_2211);
        preload(64'h40,  64'h0A0B_0C0D_0E0F_1011);
        preload(64'h48,  64'h0000_0000_0000_BEEF);

        vecs[0]  = '{1'b1, 1'b0, 64'h10,  64'h0, 1, STAT_AOK, 80'hAABB_1122_3344_5566_7788};
        vecs[1]  = '{1'b0, 1'b0, 64'h100, 64'h0, 2, STAT_AOK, 80'h0000_CAFE_F00D_1234_5678};
        vecs[2]  = '{1'b0, 1'b1, 64'h208, 64'h0123_4567_89AB_CDEF, 1, STAT_AOK, 80'h0};
        vecs[3]  = '{1'b0, 1'b0, 64'h208, 64'h0, 3, STAT_AOK, 80'h0000_0123_4567_89AB_CDEF};
        vecs[4]  = '{1'b1, 1'b0, 64'hFF8, 64'h0, 1, STAT_ADR, 80'h0};
        vecs[5]  = '{1'b1, 1'b0, 64'hFF6, 64'h0, 1, STAT_AOK, 80'hC0DE_0102_0304_0506_0708};
        vecs[6]  = '{1'b1, 1'b0, 64'hFF7, 64'h0, 1, STAT_ADR, 80'h0};
        vecs[7]  = '{1'b0, 1'b0, 64'hFF8, 64'h0, 2, STAT_AOK, 80'h0000_8877_6655_4433_2211};
        vecs[8]  = '{1'b0, 1'b0, 64'hFF9, 64'h0, 1, STAT_ADR, 80'h0};
        vecs[9]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h55, 1, STAT_ADR, 80'h0};
        vecs[10] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, STAT_ADR, 80'h0};

        repeat (3) @(negedge clk);
        check_output("reset_mem_req", {79'h0, mem_req}, 80'h0);
        check_output("reset_mem_we", {79'h0, mem_we}, 80'h0);
        check_output("reset_mem_addr", {16'h0, mem_addr}, 80'h0);
        check_output("reset_mem_wdata", {16'h0, mem_wdata}, 80'h0);
        check_output("reset_dones", {78'h0, f_done, m_done}, 80'h0);
        check_output("reset_f_instr", f_instr, 80'h0);
        check_output("reset_m_rdata", {16'h0, m_rdata}, 80'h0);
        check_output("reset_stats", {76'h0, f_stat, m_stat}, {76'h0, STAT_AOK, STAT_AOK});
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch at 0x10 with single-cycle memory: two beats, done on the fourth edge.
        $display("[TB] fetch timing sequence");
        mem_lat = 1; f_pc = 64'h10; f_req = 1'b1; edges = 0; got = 1'b0; log_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            edges++;
            if (mem_req) log_q.push_back(mem_addr);
            if (f_done) begin got = 1'b1; break; end
        end
        a0 = (log_q.size() > 0) ? log_q[0] : '1;
        a1 = (log_q.size() > 1) ? log_q[1] : '1;
        check_output("fetch_done_cycle", 80'(edges), 80'd4);
        check_output("fetch_beat_count", 80'(log_q.size()), 80'd2);
        check_output("fetch_addr_lo", {16'h0, a0}, 80'h10);
        check_output("fetch_addr_hi", {16'h0, a1}, 80'h18);
        check_output("fetch_instr", f_instr, 80'hAABB_1122_3344_5566_7788);
        check_output("fetch_stat", {78'h0, f_stat}, {78'h0, STAT_AOK});
        f_req = 1'b0;
        @(negedge clk);
        check_output("fetch_done_pulse", {79'h0, f_done}, 80'h0);

        $display("[TB] vector table");
        for (int i = 0; i < 11; i++) begin
            ref_op(vecs[i].is_fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata, exp_stat, exp_data);
            apply_stimulus(vecs[i].is_fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                           got_stat, got_data, proto_bad);
            check_output($sformatf("vec%0d_stat", i), {78'h0, got_stat}, {78'h0, vecs[i].exp_stat});
            check_output($sformatf("vec%0d_data", i), got_data, vecs[i].exp_data);
            check_output($sformatf("vec%0d_handshake", i), {79'h0, proto_bad}, 80'h0);
        end

        // Simultaneous requests: data goes first, fetch stays stalled throughout.
        $display("[TB] simultaneous request sequence");
        mem_lat = 1; f_pc = 64'h10; m_addr = 64'h100; m_we = 1'b0; f_req = 1'b1; m_req = 1'b1;
        first_addr = '1; first_we = 1'b1; found = 1'b0; m_at = -1; f_at = 99; stall_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && !found) begin first_addr = mem_addr; first_we = mem_we; found = 1'b1; end
            if (m_done) begin
                m_at = i;
                check_output("simul_m_rdata", {16'h0, m_rdata}, 80'h0000_CAFE_F00D_1234_5678);
                m_req = 1'b0;
            end
            if (f_done) begin f_at = i; break; end
            if (!f_stall_req) stall_bad = 1'b1;
        end
        check_output("simul_first_beat", {15'h0, first_we, first_addr}, 80'h100);
        check_output("simul_order", {79'h0, (m_at >= 0) && (m_at < f_at)}, 80'h1);
        check_output("simul_f_instr", f_instr, 80'hAABB_1122_3344_5566_7788);
        check_output("simul_f_stall", {79'h0, stall_bad}, 80'h0);
        f_req = 1'b0; m_req = 1'b0;
        @(negedge clk);

        // Write with three-cycle memory: request fields must hold until the ack.
        $display("[TB] slow write sequence");
        ref_op(1'b0, 1'b1, 64'h200, 64'hDEAD, exp_stat, exp_data);
        mem_lat = 3; m_we = 1'b1; m_addr = 64'h200; m_wdata = 64'hDEAD; m_req = 1'b1;
        high = 0; unstable = 1'b0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) begin
                high++;
                if (mem_addr !== 64'h200 || mem_wdata !== 64'hDEAD || mem_we !== 1'b1) unstable = 1'b1;
            end
            if (m_done) begin got = 1'b1; break; end
        end
        check_output("write_done_seen", {79'h0, got}, 80'h1);
        check_output("write_req_cycles", 80'(high), 80'd3);
        check_output("write_stable", {79'h0, unstable}, 80'h0);
        check_output("write_rdata", {16'h0, m_rdata}, 80'h0);
        check_output("write_stat", {78'h0, m_stat}, {78'h0, STAT_AOK});
        m_req = 1'b0; m_we = 1'b0;
        @(negedge clk);

        // Cancel while the second fetch beat is in flight.
        $display("[TB] cancel sequence");
        mem_lat = 2; f_pc = 64'h20; f_req = 1'b1; acks0 = ack_count; found = 1'b0; f_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 64'h28) begin found = 1'b1; break; end
        end
        check_output("cancel_hi_beat_seen", {79'h0, found}, 80'h1);
        f_cancel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (f_done) f_seen = 1'b1;
        end
        check_output("cancel_no_done", {79'h0, f_seen}, 80'h0);
        check_output("cancel_beats_done", 80'(ack_count - acks0), 80'd2);
        check_output("cancel_req_idle", {79'h0, mem_req}, 80'h0);
        f_req = 1'b0; f_cancel = 1'b0;
        @(negedge clk);
        ref_op(1'b1, 1'b0, 64'h40, 64'h0, exp_stat, exp_data);
        apply_stimulus(1'b1, 1'b0, 64'h40, 64'h0, 1, got_stat, got_data, proto_bad);
        check_output("after_cancel_instr", got_data, 80'hBEEF_0A0B_0C0D_0E0F_1011);
        check_output("after_cancel_stat", {78'h0, got_stat}, {78'h0, STAT_AOK});

        // Ack never arrives: the watchdog gives up after 15 waiting cycles.
        $display("[TB] timeout sequence");
        hold_ack = 1'b1; m_we = 1'b0; m_addr = 64'h300; m_req = 1'b1; high = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) high++;
            if (m_done) begin got = 1'b1; break; end
        end
        check_output("timeout_done_seen", {79'h0, got}, 80'h1);
        check_output("timeout_req_cycles", 80'(high), 80'd15);
        check_output("timeout_stat", {78'h0, m_stat}, {78'h0, STAT_ADR});
        check_output("timeout_req_dropped", {79'h0, mem_req}, 80'h0);
        m_req = 1'b0; hold_ack = 1'b0;
        @(negedge clk);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0)
                raddr = 64'(MEM_BYTES - 16 + int'($urandom_range(0, 15)));
            else
                raddr = 64'($urandom_range(0, 511)) * 64'd8;
            m_wdata = {$urandom, $urandom};
            ref_op(kind == 0, kind == 2, raddr, m_wdata, exp_stat, exp_data);
            apply_stimulus(kind == 0, kind == 2, raddr, m_wdata, int'($urandom_range(1, 3)),
                           got_stat, got_data, proto_bad);
            check_output($sformatf("rand%0d_stat", i), {78'h0, got_stat}, {78'h0, exp_stat});
            check_output($sformatf("rand%0d_data", i), got_data, exp_data);
            check_output($sformatf("rand%0d_handshake", i), {79'h0, proto_bad}, 80'h0);
        end

        // Reset in the middle of a beat clears outputs without waiting for a clock edge.
        $display("[TB] reset mid-beat sequence");
        hold_ack = 1'b1; m_we = 1'b0; m_addr = 64'h100; m_req = 1'b1;
        repeat (3) @(negedge clk);
        check_output("midbeat_req_active", {79'h0, mem_req}, 80'h1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midbeat_reset_req", {79'h0, mem_req}, 80'h0);
        check_output("midbeat_reset_addr", {16'h0, mem_addr}, 80'h0);
        check_output("midbeat_reset_misc", {76'h0, mem_we, f_done, m_done, |m_rdata}, 80'h0);
        check_output("midbeat_reset_instr", f_instr, 80'h0);
        check_output("midbeat_reset_stats", {76'h0, f_stat, m_stat}, {76'h0, STAT_AOK, STAT_AOK});
        m_req = 1'b0; hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
